// File: rtl/led_matrix_scanner.sv
// Column-scanning driver for a 5x7 LED matrix fed by a Y-symmetric image (col_2/col_1/col_0).
// Optional whole-image blinking is compiled in with the MATRIX_BLINK_EN macro.
module led_matrix_scanner #(
    parameter int PRESCALE     = 50000,
    parameter int BLINK_FRAMES = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       blink,
    input  logic [6:0] col_2,
    input  logic [6:0] col_1,
    input  logic [6:0] col_0,
    output logic [4:0] matrix_col,
    output logic [6:0] matrix_row,
    output logic       frame_done
);

    localparam int            PW        = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] PRESC_ONE = PW'(1);

    logic [PW-1:0] presc;
    logic [2:0]    col_idx;
    logic [6:0]    snap_2;
    logic [6:0]    snap_1;
    logic [6:0]    snap_0;
    logic [6:0]    col_bits;
    logic [4:0]    col_sel;
    logic          dwell_end;
    logic          row_dark;

    assign dwell_end = (presc == PRESC_MAX);

    // Mirror the three stored image columns onto five physical columns.
    always_comb begin
        col_bits = 7'h00;
        col_sel  = 5'b11111;
        case (col_idx)
            3'd0:    begin col_bits = snap_2; col_sel = 5'b11110; end
            3'd1:    begin col_bits = snap_1; col_sel = 5'b11101; end
            3'd2:    begin col_bits = snap_0; col_sel = 5'b11011; end
            3'd3:    begin col_bits = snap_1; col_sel = 5'b10111; end
            3'd4:    begin col_bits = snap_2; col_sel = 5'b01111; end
            default: begin col_bits = 7'h00;  col_sel = 5'b11111; end
        endcase
    end

`ifdef MATRIX_BLINK_EN
    localparam logic [7:0] FRAME_MAX = 8'(BLINK_FRAMES - 1);

    logic [7:0] frame_cnt;
    logic       phase_on;

    assign row_dark = blink && !phase_on;

    // Blink phase flips every BLINK_FRAMES completed frames while blinking.
    always_ff @(posedge clk) begin
        if (reset || !enable || !blink) begin
            frame_cnt <= 8'd0;
            phase_on  <= 1'b1;
        end else if (frame_done) begin
            if (frame_cnt == FRAME_MAX) begin
                frame_cnt <= 8'd0;
                phase_on  <= !phase_on;
            end else begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end
`else
    localparam int unused_blink_frames = BLINK_FRAMES;
    logic unused_blink;

    assign unused_blink = blink;
    assign row_dark     = 1'b0;
`endif

    // Scan counters, frame snapshot and registered pin drive.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc      <= '0;
            col_idx    <= 3'd0;
            snap_2     <= 7'h00;
            snap_1     <= 7'h00;
            snap_0     <= 7'h00;
            matrix_col <= 5'b11111;
            matrix_row <= 7'h7F;
            frame_done <= 1'b0;
        end else if (!enable) begin
            presc      <= '0;
            col_idx    <= 3'd0;
            matrix_col <= 5'b11111;
            matrix_row <= 7'h7F;
            frame_done <= 1'b0;
        end else begin
            // Whole image is captured once per frame so a frame never tears.
            if (presc == '0 && col_idx == 3'd0) begin
                snap_2 <= col_2;
                snap_1 <= col_1;
                snap_0 <= col_0;
            end
            if (dwell_end) begin
                presc   <= '0;
                col_idx <= (col_idx == 3'd4) ? 3'd0 : col_idx + 3'd1;
            end else begin
                presc   <= presc + PRESC_ONE;
            end
            frame_done <= dwell_end && (col_idx == 3'd4);
            if (presc == '0) begin
                matrix_col <= 5'b11111;
                matrix_row <= 7'h7F;
            end else begin
                matrix_col <= col_sel;
                matrix_row <= row_dark ? 7'h7F : ~col_bits;
            end
        end
    end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Self-checking bench for led_matrix_scanner (PRESCALE=4, BLINK_FRAMES=2) against a
// cycle-count based reference model; directed scenarios plus randomized stimulus.
module tb_led_matrix_scanner;

    localparam int P  = 4;
    localparam int BF = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       blink;
    logic [6:0] col_2;
    logic [6:0] col_1;
    logic [6:0] col_0;
    logic [4:0] matrix_col;
    logic [6:0] matrix_row;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    // Reference model state: cycles since scan start, frames seen while blinking.
    int         m_t;
    int         m_frames;
    logic [6:0] m_snap [3];
    logic [4:0] exp_col;
    logic [6:0] exp_row;
    logic       exp_fd;

    led_matrix_scanner #(.PRESCALE(P), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .reset(reset), .enable(enable), .blink(blink),
        .col_2(col_2), .col_1(col_1), .col_0(col_0),
        .matrix_col(matrix_col), .matrix_row(matrix_row), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Predict what the outputs show after the coming clock edge.
    task automatic model_step();
        int p;
        int c;
        logic [6:0] img;
        logic dark;
        if (reset) begin
            exp_col = 5'h1F; exp_row = 7'h7F; exp_fd = 1'b0;
            m_t = 0; m_frames = 0;
            m_snap[0] = 7'h00; m_snap[1] = 7'h00; m_snap[2] = 7'h00;
        end else if (!enable) begin
            exp_col = 5'h1F; exp_row = 7'h7F; exp_fd = 1'b0;
            m_t = 0; m_frames = 0;
        end else begin
            p = m_t % P;
            c = (m_t / P) % 5;
            if (m_t % (5 * P) == 0) begin
                m_snap[2] = col_2; m_snap[1] = col_1; m_snap[0] = col_0;
            end
            img  = m_snap[(c > 2) ? (c - 2) : (2 - c)];
            dark = 1'b0;
`ifdef MATRIX_BLINK_EN
            dark = blink && ((m_frames / BF) % 2 == 1);
            if (!blink) m_frames = 0;
            else if (exp_fd) m_frames = m_frames + 1;
`endif
            exp_col = (p == 0) ? 5'h1F : (5'h1F ^ 5'(1 << c));
            exp_row = (p == 0 || dark) ? 7'h7F : ~img;
            exp_fd  = (p == P - 1) && (c == 4);
            m_t = m_t + 1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic restart();
        enable = 1'b0;
        tick();
        enable = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({matrix_col, matrix_row, frame_done} !== {5'h1F, 7'h7F, 1'b0}) begin
                errors++;
                $display("FAIL reset: got col=%h row=%h fd=%b, want col=1f row=7f fd=0",
                         matrix_col, matrix_row, frame_done);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_pattern();
        int fd_count = 0;
        logic [11:0] want;
        col_2 = 7'h51; col_1 = 7'h1C; col_0 = 7'h7F;
        restart();
        for (int cyc = 0; cyc < 40; cyc++) begin
            tick();
            if (frame_done) fd_count++;
            checks++;
            if ({matrix_col, matrix_row, frame_done} !== {exp_col, exp_row, exp_fd}) begin
                errors++;
                $display("FAIL pattern_model cyc=%0d: got %h/%h/%b, want %h/%h/%b", cyc + 1,
                         matrix_col, matrix_row, frame_done, exp_col, exp_row, exp_fd);
            end
            case (cyc + 1)
                2: want = {5'h1E, 7'h2E};  5: want = {5'h1F, 7'h7F};
                6: want = {5'h1D, 7'h63}; 10: want = {5'h1B, 7'h00};
                14: want = {5'h17, 7'h63}; 18: want = {5'h0F, 7'h2E};
                default: want = 12'hFFF;
            endcase
            if (want != 12'hFFF) begin
                checks++;
                if ({matrix_col, matrix_row} !== want) begin
                    errors++;
                    $display("FAIL pattern_const cyc=%0d: got %h/%h, want %h/%h", cyc + 1,
                             matrix_col, matrix_row, want[11:7], want[6:0]);
                end
            end
        end
        checks++;
        if (fd_count != 2) begin
            errors++;
            $display("FAIL frame_rate: got %0d pulses, want 2 in 40 cycles", fd_count);
        end
    endtask

    task automatic test_midframe_change();
        logic [11:0] want;
        col_2 = 7'h51; col_1 = 7'h1C; col_0 = 7'h7F;
        restart();
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (cyc == 9) col_1 = 7'h03;
            tick();
            checks++;
            if ({matrix_col, matrix_row, frame_done} !== {exp_col, exp_row, exp_fd}) begin
                errors++;
                $display("FAIL midframe_model cyc=%0d: got %h/%h/%b, want %h/%h/%b", cyc + 1,
                         matrix_col, matrix_row, frame_done, exp_col, exp_row, exp_fd);
            end
            case (cyc + 1)
                14: want = {5'h17, 7'h63}; 18: want = {5'h0F, 7'h2E};
                26: want = {5'h1D, 7'h7C};
                default: want = 12'hFFF;
            endcase
            if (want != 12'hFFF) begin
                checks++;
                if ({matrix_col, matrix_row} !== want) begin
                    errors++;
                    $display("FAIL midframe_const cyc=%0d: got %h/%h, want %h/%h", cyc + 1,
                             matrix_col, matrix_row, want[11:7], want[6:0]);
                end
            end
        end
    endtask

    task automatic test_enable_drop();
        logic [12:0] want;
        col_2 = 7'h51; col_1 = 7'h1C; col_0 = 7'h7F;
        restart();
        for (int cyc = 0; cyc < 24; cyc++) begin
            if (cyc == 13) enable = 1'b0;
            if (cyc == 16) enable = 1'b1;
            tick();
            checks++;
            if ({matrix_col, matrix_row, frame_done} !== {exp_col, exp_row, exp_fd}) begin
                errors++;
                $display("FAIL enable_model cyc=%0d: got %h/%h/%b, want %h/%h/%b", cyc + 1,
                         matrix_col, matrix_row, frame_done, exp_col, exp_row, exp_fd);
            end
            case (cyc + 1)
                14: want = {5'h1F, 7'h7F, 1'b0}; 17: want = {5'h1F, 7'h7F, 1'b0};
                18: want = {5'h1E, 7'h2E, 1'b0};
                default: want = 13'h1FFF;
            endcase
            if (want != 13'h1FFF) begin
                checks++;
                if ({matrix_col, matrix_row, frame_done} !== want) begin
                    errors++;
                    $display("FAIL enable_const cyc=%0d: got %h/%h/%b, want %h/%h/%b", cyc + 1,
                             matrix_col, matrix_row, frame_done, want[12:8], want[7:1], want[0]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int fd_count = 0;
        restart();
        for (int cyc = 0; cyc < 40; cyc++) begin
            reset = (cyc == 18);
            tick();
            if (cyc + 1 >= 19 && cyc + 1 <= 38 && frame_done) fd_count++;
            checks++;
            if ({matrix_col, matrix_row, frame_done} !== {exp_col, exp_row, exp_fd}) begin
                errors++;
                $display("FAIL reset_mid_model cyc=%0d: got %h/%h/%b, want %h/%h/%b", cyc + 1,
                         matrix_col, matrix_row, frame_done, exp_col, exp_row, exp_fd);
            end
            if (cyc + 1 == 19 || cyc + 1 == 39) begin
                checks++;
                if (frame_done !== (cyc + 1 == 39) ||
                    (cyc + 1 == 19 && {matrix_col, matrix_row} !== {5'h1F, 7'h7F})) begin
                    errors++;
                    $display("FAIL reset_mid_const cyc=%0d: got %h/%h/%b", cyc + 1,
                             matrix_col, matrix_row, frame_done);
                end
            end
        end
        reset = 1'b0;
        checks++;
        if (fd_count != 0) begin
            errors++;
            $display("FAIL aborted_frame: got %0d pulses, want 0", fd_count);
        end
    endtask

    task automatic test_blink();
        logic [6:0] want;
        col_2 = 7'h51; col_1 = 7'h1C; col_0 = 7'h7F;
        blink = 1'b1;
        restart();
        for (int cyc = 0; cyc < 100; cyc++) begin
            tick();
            checks++;
            if ({matrix_col, matrix_row, frame_done} !== {exp_col, exp_row, exp_fd}) begin
                errors++;
                $display("FAIL blink_model cyc=%0d: got %h/%h/%b, want %h/%h/%b", cyc + 1,
                         matrix_col, matrix_row, frame_done, exp_col, exp_row, exp_fd);
            end
            if (cyc + 1 == 2 || cyc + 1 == 42 || cyc + 1 == 82) begin
                want = 7'h2E;
`ifdef MATRIX_BLINK_EN
                if (cyc + 1 == 42) want = 7'h7F;
`endif
                checks++;
                if (matrix_row !== want) begin
                    errors++;
                    $display("FAIL blink_const cyc=%0d: got row=%h, want row=%h", cyc + 1,
                             matrix_row, want);
                end
            end
        end
        blink = 1'b0;
    endtask

    task automatic test_random();
        restart();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if ($urandom_range(7, 0) == 0) col_2 = 7'($urandom);
            if ($urandom_range(7, 0) == 0) col_1 = 7'($urandom);
            if ($urandom_range(7, 0) == 0) col_0 = 7'($urandom);
            if ($urandom_range(39, 0) == 0) enable = !enable;
            else if (!enable && $urandom_range(3, 0) == 0) enable = 1'b1;
            reset = ($urandom_range(99, 0) == 0);
            blink = ($urandom_range(199, 0) == 0) ? !blink : blink;
            tick();
            checks++;
            if ({matrix_col, matrix_row, frame_done} !== {exp_col, exp_row, exp_fd}) begin
                errors++;
                $display("FAIL random cyc=%0d: got %h/%h/%b, want %h/%h/%b", cyc + 1,
                         matrix_col, matrix_row, frame_done, exp_col, exp_row, exp_fd);
            end
        end
        reset = 1'b0;
        blink = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; blink = 1'b0;
        col_2 = 7'h00; col_1 = 7'h00; col_0 = 7'h00;
        m_t = 0; m_frames = 0;
        m_snap[0] = 7'h00; m_snap[1] = 7'h00; m_snap[2] = 7'h00;
        exp_col = 5'h1F; exp_row = 7'h7F; exp_fd = 1'b0;
        @(negedge clk);
        test_reset();
        test_pattern();
        test_midframe_change();
        test_enable_drop();
        test_reset_mid();
        test_blink();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
